// File: rtl/comporta_multi_uc.sv
// comporta_multi_uc: reversible gate ramp controller with internal step timer.
// Define COMPORTA_AUTO_FECHA_EN to auto-close after HOLD_CYC cycles fully open.
module comporta_multi_uc #(
    parameter int MAX_POS      = 7,
    parameter int POS_W        = 3,
    parameter int INTERVAL_CYC = 1000,
    parameter int CNT_W        = 10,
    parameter int HOLD_CYC     = 5000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             abrir,
    input  logic             comando,
    input  logic             peso_max_zero,
    output logic [POS_W-1:0] posicao,
    output logic             aberta,
    output logic             fechada,
    output logic             movendo,
    output logic [3:0]       db_estado
);

    localparam logic [2:0] INICIAL  = 3'd0;
    localparam logic [2:0] PREPARA  = 3'd1;
    localparam logic [2:0] ABRINDO  = 3'd2;
    localparam logic [2:0] ABERTA   = 3'd3;
    localparam logic [2:0] FECHANDO = 3'd4;

    localparam logic [POS_W-1:0] POS_MAX = POS_W'(MAX_POS);
    localparam logic [CNT_W-1:0] CNT_FIM = CNT_W'(INTERVAL_CYC - 1);

    if (MAX_POS < 1 || (2 ** POS_W) <= MAX_POS || INTERVAL_CYC < 2 ||
        (2 ** CNT_W) < INTERVAL_CYC || HOLD_CYC < 1) begin : gParamInvalido
        $error("comporta_multi_uc: invalid parameter set");
    end

    logic [2:0]       estado;
    logic [2:0]       estadoProx;
    logic [POS_W-1:0] posicaoProx;
    logic [POS_W-1:0] posSobe;
    logic [POS_W-1:0] posDesce;
    logic [CNT_W-1:0] contador;
    logic [CNT_W-1:0] contadorProx;
    logic             podeBase;
    logic             podeAbrir;
    logic             fimIntervalo;

    assign podeBase     = abrir && (comando || !peso_max_zero);
    assign fimIntervalo = (contador == CNT_FIM);
    assign posSobe      = posicao + 1'b1;
    assign posDesce     = posicao - 1'b1;

`ifdef COMPORTA_AUTO_FECHA_EN
    localparam int HOLD_W = $clog2(HOLD_CYC + 1);
    localparam logic [HOLD_W-1:0] HOLD_FIM = HOLD_W'(HOLD_CYC - 1);

    logic [HOLD_W-1:0] espera;
    logic              abrirAnt;
    logic              bloqueado;
    logic              autoFecha;

    assign autoFecha = (estado == ABERTA) && (espera == HOLD_FIM);
    // after an auto-close only a fresh rising edge of abrir may reopen
    assign podeAbrir = podeBase && (!bloqueado || !abrirAnt);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            espera    <= '0;
            abrirAnt  <= 1'b0;
            bloqueado <= 1'b0;
        end else begin
            abrirAnt <= abrir;
            espera   <= (estado == ABERTA) ? espera + 1'b1 : '0;
            if (autoFecha && abrir) begin
                bloqueado <= 1'b1;
            end else if (!abrir) begin
                bloqueado <= 1'b0;
            end
        end
    end
`else
    assign podeAbrir = podeBase;
`endif

    always_comb begin
        estadoProx   = estado;
        posicaoProx  = posicao;
        contadorProx = contador;
        case (estado)
            INICIAL: begin
                posicaoProx  = '0;
                contadorProx = '0;
                if (podeAbrir) begin
                    estadoProx = PREPARA;
                end
            end
            PREPARA: begin
                contadorProx = '0;
                estadoProx   = ABRINDO;
            end
            ABRINDO: begin
                if (!abrir) begin
                    estadoProx   = FECHANDO;
                    contadorProx = '0;
                end else if (posicao >= POS_MAX) begin
                    // reopened from FECHANDO before leaving the top position
                    estadoProx   = ABERTA;
                    contadorProx = '0;
                end else if (fimIntervalo) begin
                    contadorProx = '0;
                    posicaoProx  = posSobe;
                    if (posSobe == POS_MAX) begin
                        estadoProx = ABERTA;
                    end
                end else begin
                    contadorProx = contador + 1'b1;
                end
            end
            ABERTA: begin
                posicaoProx  = POS_MAX;
                contadorProx = '0;
                if (!abrir) begin
                    estadoProx = FECHANDO;
                end
`ifdef COMPORTA_AUTO_FECHA_EN
                else if (autoFecha) begin
                    estadoProx = FECHANDO;
                end
`endif
            end
            FECHANDO: begin
                if (podeAbrir) begin
                    estadoProx   = ABRINDO;
                    contadorProx = '0;
                end else if (posicao == '0) begin
                    estadoProx   = INICIAL;
                    contadorProx = '0;
                end else if (fimIntervalo) begin
                    contadorProx = '0;
                    posicaoProx  = posDesce;
                    if (posDesce == '0) begin
                        estadoProx = INICIAL;
                    end
                end else begin
                    contadorProx = contador + 1'b1;
                end
            end
            default: begin
                estadoProx   = INICIAL;
                posicaoProx  = '0;
                contadorProx = '0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado   <= INICIAL;
            posicao  <= '0;
            contador <= '0;
        end else begin
            estado   <= estadoProx;
            posicao  <= posicaoProx;
            contador <= contadorProx;
        end
    end

    assign fechada = (posicao == '0);

    always_comb begin
        aberta    = (estado == ABERTA);
        movendo   = (estado == ABRINDO) || (estado == FECHANDO);
        db_estado = 4'hF;
        case (estado)
            INICIAL, PREPARA, ABRINDO, ABERTA, FECHANDO:
                db_estado = {1'b0, estado};
            default:
                db_estado = 4'hF;
        endcase
    end

endmodule

// File: tb/tb_comporta_multi_uc.sv
// tb_comporta_multi_uc: directed scenarios plus randomized run
// checked against a cycle-level behavioural model of the gate.
module tb_comporta_multi_uc;

    localparam int T_MAX  = 3;
    localparam int T_INT  = 4;
    localparam int T_HOLD = 10;

    logic       clock = 1'b0;
    logic       reset;
    logic       abrir;
    logic       comando;
    logic       peso_max_zero;
    logic [1:0] posicao;
    logic       aberta;
    logic       fechada;
    logic       movendo;
    logic [3:0] db_estado;
    logic [8:0] obs;

    int checks = 0;
    int errors = 0;

    int mMode;
    int mPos;
    int mTicks;
    int mHold;
    bit mLock;
    bit mPrev;

    comporta_multi_uc #(
        .MAX_POS(T_MAX),
        .POS_W(2),
        .INTERVAL_CYC(T_INT),
        .CNT_W(3),
        .HOLD_CYC(T_HOLD)
    ) dut (
        .clock(clock),
        .reset(reset),
        .abrir(abrir),
        .comando(comando),
        .peso_max_zero(peso_max_zero),
        .posicao(posicao),
        .aberta(aberta),
        .fechada(fechada),
        .movendo(movendo),
        .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    assign obs = {posicao, aberta, fechada, movendo, db_estado};

    function automatic void model_reset();
        mMode  = 0;
        mPos   = 0;
        mTicks = 0;
        mHold  = 0;
        mLock  = 0;
        mPrev  = 0;
    endfunction

    // one clock of gate behaviour; mode numbers are the debug codes
    function automatic void model_step();
        bit pode;
        pode = abrir && (comando || !peso_max_zero);
`ifdef COMPORTA_AUTO_FECHA_EN
        if (mLock && !(abrir && !mPrev)) pode = 0;
`endif
        if (mMode != 3) mHold = 0;
        case (mMode)
            0: if (pode) mMode = 1;
            1: begin mMode = 2; mTicks = 0; end
            2: begin
                if (!abrir) begin
                    mMode = 4; mTicks = 0;
                end else if (mPos == T_MAX) begin
                    mMode = 3;
                end else begin
                    mTicks++;
                    if (mTicks == T_INT) begin
                        mTicks = 0; mPos++;
                        if (mPos == T_MAX) mMode = 3;
                    end
                end
            end
            3: begin
                if (!abrir) begin
                    mMode = 4; mTicks = 0;
                end
`ifdef COMPORTA_AUTO_FECHA_EN
                else begin
                    mHold++;
                    if (mHold == T_HOLD) begin
                        mMode = 4; mTicks = 0; mLock = 1;
                    end
                end
`endif
            end
            4: begin
                if (pode) begin
                    mMode = 2; mTicks = 0;
                end else if (mPos == 0) begin
                    mMode = 0;
                end else begin
                    mTicks++;
                    if (mTicks == T_INT) begin
                        mTicks = 0; mPos--;
                        if (mPos == 0) mMode = 0;
                    end
                end
            end
            default: mMode = 0;
        endcase
`ifdef COMPORTA_AUTO_FECHA_EN
        if (!abrir) mLock = 0;
        mPrev = abrir;
`endif
    endfunction

    function automatic logic [8:0] exp_obs();
        return {2'(mPos), (mMode == 3), (mPos == 0),
                (mMode == 2 || mMode == 4), 4'(mMode)};
    endfunction

    task automatic cyc();
        @(posedge clock);
        if (reset) model_reset();
        else model_step();
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b1; abrir = 1'b0; comando = 1'b0; peso_max_zero = 1'b0;
        model_reset();
        #3;
        checks++;
        if (obs !== 9'b00_0_1_0_0000) begin
            errors++;
            $display("FAIL reset_async: got %b expected %b", obs, 9'b000100000);
        end
        cyc(); cyc();
        reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            cyc();
            checks++;
            if (obs !== 9'b00_0_1_0_0000 || obs !== exp_obs()) begin
                errors++;
                $display("FAIL reset_idle: cycle %0d got %b expected %b", k, obs, exp_obs());
            end
        end
    endtask

    task automatic test_open();
        abrir = 1'b1; peso_max_zero = 1'b0; comando = 1'b0;
        cyc();
        checks++;
        if (db_estado !== 4'd1 || movendo !== 1'b0) begin
            errors++;
            $display("FAIL open_prepara: got db=%0d expected 1", db_estado);
        end
        cyc();
        checks++;
        if (db_estado !== 4'd2 || posicao !== 2'd0 || movendo !== 1'b1) begin
            errors++;
            $display("FAIL open_abrindo: got db=%0d pos=%0d expected db=2 pos=0", db_estado, posicao);
        end
        for (int k = 1; k <= 12; k++) begin
            cyc();
            checks++;
            if (obs !== exp_obs()) begin
                errors++;
                $display("FAIL open_ramp: k=%0d got %b expected %b", k, obs, exp_obs());
            end
            if (k % 4 == 0) begin
                checks++;
                if (posicao !== 2'(k / 4)) begin
                    errors++;
                    $display("FAIL open_step: k=%0d got pos=%0d expected %0d", k, posicao, k / 4);
                end
            end
        end
        checks++;
        if (aberta !== 1'b1 || db_estado !== 4'd3 || movendo !== 1'b0) begin
            errors++;
            $display("FAIL open_done: got aberta=%b db=%0d expected aberta=1 db=3", aberta, db_estado);
        end
        abrir = 1'b0;
        for (int k = 0; k < 13; k++) begin
            cyc();
            checks++;
            if (obs !== exp_obs()) begin
                errors++;
                $display("FAIL open_close: k=%0d got %b expected %b", k, obs, exp_obs());
            end
        end
        checks++;
        if (db_estado !== 4'd0 || fechada !== 1'b1) begin
            errors++;
            $display("FAIL open_closed: got db=%0d fechada=%b expected db=0 fechada=1", db_estado, fechada);
        end
    endtask

    task automatic test_peso_block();
        abrir = 1'b1; peso_max_zero = 1'b1; comando = 1'b0;
        for (int k = 0; k < 20; k++) begin
            cyc();
            checks++;
            if (db_estado !== 4'd0 || posicao !== 2'd0) begin
                errors++;
                $display("FAIL peso_block: k=%0d got db=%0d pos=%0d expected 0 0", k, db_estado, posicao);
            end
        end
        comando = 1'b1;
        cyc();
        checks++;
        if (db_estado !== 4'd1) begin
            errors++;
            $display("FAIL peso_comando: got db=%0d expected 1", db_estado);
        end
        for (int k = 0; k < 13; k++) begin
            cyc();
            checks++;
            if (obs !== exp_obs()) begin
                errors++;
                $display("FAIL peso_ramp: k=%0d got %b expected %b", k, obs, exp_obs());
            end
        end
        checks++;
        if (aberta !== 1'b1 || posicao !== 2'd3) begin
            errors++;
            $display("FAIL peso_open: got aberta=%b pos=%0d expected 1 3", aberta, posicao);
        end
        abrir = 1'b0; comando = 1'b0; peso_max_zero = 1'b0;
        repeat (13) cyc();
        checks++;
        if (db_estado !== 4'd0 || fechada !== 1'b1) begin
            errors++;
            $display("FAIL peso_closed: got db=%0d expected 0", db_estado);
        end
    endtask

    task automatic test_reversal();
        abrir = 1'b1;
        repeat (6) cyc();
        checks++;
        if (posicao !== 2'd1) begin
            errors++;
            $display("FAIL rev_first: got pos=%0d expected 1", posicao);
        end
        repeat (3) cyc();
        abrir = 1'b0;
        cyc();
        checks++;
        if (posicao !== 2'd1 || db_estado !== 4'd4 || obs !== exp_obs()) begin
            errors++;
            $display("FAIL rev_enter: got pos=%0d db=%0d expected pos=1 db=4", posicao, db_estado);
        end
        repeat (3) cyc();
        checks++;
        if (posicao !== 2'd1 || db_estado !== 4'd4) begin
            errors++;
            $display("FAIL rev_hold: got pos=%0d db=%0d expected 1 4", posicao, db_estado);
        end
        cyc();
        checks++;
        if (posicao !== 2'd0 || db_estado !== 4'd0 || fechada !== 1'b1) begin
            errors++;
            $display("FAIL rev_closed: got pos=%0d db=%0d expected 0 0", posicao, db_estado);
        end
    endtask

    task automatic test_reopen();
        abrir = 1'b1;
        repeat (14) cyc();
        abrir = 1'b0;
        cyc();
        repeat (4) cyc();
        checks++;
        if (posicao !== 2'd2 || db_estado !== 4'd4) begin
            errors++;
            $display("FAIL reopen_fech: got pos=%0d db=%0d expected 2 4", posicao, db_estado);
        end
        abrir = 1'b1;
        cyc();
        checks++;
        if (posicao !== 2'd2 || db_estado !== 4'd2) begin
            errors++;
            $display("FAIL reopen_abr: got pos=%0d db=%0d expected 2 2", posicao, db_estado);
        end
        repeat (3) cyc();
        checks++;
        if (posicao !== 2'd2) begin
            errors++;
            $display("FAIL reopen_cnt: got pos=%0d expected 2", posicao);
        end
        cyc();
        checks++;
        if (posicao !== 2'd3 || db_estado !== 4'd3 || obs !== exp_obs()) begin
            errors++;
            $display("FAIL reopen_top: got pos=%0d db=%0d expected 3 3", posicao, db_estado);
        end
        abrir = 1'b0;
        repeat (7) cyc();
        #1 reset = 1'b1;
        #1;
        checks++;
        if (posicao !== 2'd0 || db_estado !== 4'd0 || fechada !== 1'b1) begin
            errors++;
            $display("FAIL reopen_async_rst: got pos=%0d db=%0d expected 0 0", posicao, db_estado);
        end
        model_reset();
        @(negedge clock);
        reset = 1'b0;
        cyc();
        checks++;
        if (obs !== exp_obs()) begin
            errors++;
            $display("FAIL reopen_after_rst: got %b expected %b", obs, exp_obs());
        end
    endtask

`ifdef COMPORTA_AUTO_FECHA_EN
    task automatic test_auto_fecha();
        abrir = 1'b1; peso_max_zero = 1'b0; comando = 1'b0;
        repeat (14) cyc();
        for (int k = 1; k <= 10; k++) begin
            cyc();
            checks++;
            if (db_estado !== ((k < 10) ? 4'd3 : 4'd4)) begin
                errors++;
                $display("FAIL auto_hold: k=%0d got db=%0d", k, db_estado);
            end
        end
        repeat (12) cyc();
        checks++;
        if (db_estado !== 4'd0 || posicao !== 2'd0) begin
            errors++;
            $display("FAIL auto_closed: got db=%0d pos=%0d expected 0 0", db_estado, posicao);
        end
        repeat (5) cyc();
        checks++;
        if (db_estado !== 4'd0) begin
            errors++;
            $display("FAIL auto_locked: got db=%0d expected 0", db_estado);
        end
        abrir = 1'b0;
        cyc();
        abrir = 1'b1;
        cyc();
        checks++;
        if (db_estado !== 4'd1 || obs !== exp_obs()) begin
            errors++;
            $display("FAIL auto_rearm: got db=%0d expected 1", db_estado);
        end
        abrir = 1'b0;
        repeat (4) cyc();
    endtask
`endif

    task automatic test_random();
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 15) == 0) abrir = ~abrir;
            if ($urandom_range(0, 31) == 0) peso_max_zero = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 31) == 0) comando = 1'($urandom_range(0, 1));
            cyc();
            checks++;
            if (obs !== exp_obs()) begin
                errors++;
                $display("FAIL random: k=%0d got %b expected %b", k, obs, exp_obs());
            end
        end
    endtask

    initial begin
        test_reset();
        test_open();
        test_peso_block();
        test_reversal();
        test_reopen();
`ifdef COMPORTA_AUTO_FECHA_EN
        test_auto_fecha();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
